// File: rtl/nursery_alert_if.sv
// Bundles the nursery alert controller's control inputs and status outputs.
// The controller takes the slave side; the stimulus side takes the master side.
interface nursery_alert_if;
    logic       enable;
    logic       cry;
    logic       ack;
    logic       soothe_on;
    logic       alarm;
    logic       notify;
    logic [2:0] state;
    logic [3:0] cry_cnt;

    modport master (
        output enable, cry, ack,
        input  soothe_on, alarm, notify, state, cry_cnt
    );

    modport slave (
        input  enable, cry, ack,
        output soothe_on, alarm, notify, state, cry_cnt
    );
endinterface

// File: rtl/nursery_alert_ctrl.sv
// Cry escalation controller: idle -> listen -> soothe -> alarm, then cooldown.
// One shared down-timer and a saturating 4-bit cry counter drive every stage.
module nursery_alert_ctrl #(
    parameter int unsigned WINDOW          = 8,
    parameter int unsigned CRY_THRESH      = 3,
    parameter int unsigned SOOTHE_CYCLES   = 10,
    parameter int unsigned ALARM_PERIOD    = 4,
    parameter int unsigned COOLDOWN_CYCLES = 5,
    parameter int unsigned TW              = 16
) (
    input  logic             clk,
    input  logic             rstn,
    nursery_alert_if.slave   bus
);

    localparam int unsigned CW = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LISTEN   = 3'd1;
    localparam logic [2:0] S_SOOTHE   = 3'd2;
    localparam logic [2:0] S_ALARM    = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    localparam logic [TW-1:0] T_WINDOW   = TW'(WINDOW - 1);
    localparam logic [TW-1:0] T_SOOTHE   = TW'(SOOTHE_CYCLES - 1);
    localparam logic [TW-1:0] T_PERIOD   = TW'(ALARM_PERIOD - 1);
    localparam logic [TW-1:0] T_COOLDOWN = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [CW-1:0] THRESH     = CW'(CRY_THRESH);

    logic [2:0]    state_q,  state_nx;
    logic [TW-1:0] timer_q,  timer_nx;
    logic [CW-1:0] cnt_q,    cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          expired;
    logic          soothe_q, alarm_q, notify_q;

    // Counter increment (saturating) and stage-escalation test
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        hit     = bus.cry && (cnt_inc == THRESH);
        expired = (timer_q == '0);
    end

    // Next-state logic; priority is enable, then ack, then threshold, then expiry
    always_comb begin
        state_nx = state_q;
        timer_nx = timer_q;
        cnt_nx   = cnt_q;
        if (!bus.enable) begin
            state_nx = S_IDLE;
            timer_nx = '0;
            cnt_nx   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cry) begin
                        state_nx = S_LISTEN;
                        timer_nx = T_WINDOW;
                        cnt_nx   = CW'(1);
                    end
                end
                S_LISTEN: begin
                    if (hit) begin
                        state_nx = S_SOOTHE;
                        timer_nx = T_SOOTHE;
                        cnt_nx   = '0;
                    end else if (expired) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        timer_nx = timer_q - TW'(1);
                        cnt_nx   = bus.cry ? cnt_inc : cnt_q;
                    end
                end
                S_SOOTHE: begin
                    if (bus.ack) begin
                        state_nx = S_IDLE;
                        timer_nx = '0;
                        cnt_nx   = '0;
                    end else if (hit) begin
                        state_nx = S_ALARM;
                        timer_nx = '0;
                        cnt_nx   = '0;
                    end else if (expired) begin
                        state_nx = S_COOLDOWN;
                        timer_nx = T_COOLDOWN;
                        cnt_nx   = '0;
                    end else begin
                        timer_nx = timer_q - TW'(1);
                        cnt_nx   = bus.cry ? cnt_inc : cnt_q;
                    end
                end
                S_ALARM: begin
                    cnt_nx = '0;
                    if (bus.ack) begin
                        state_nx = S_COOLDOWN;
                        timer_nx = T_COOLDOWN;
                    end else if (expired) begin
                        timer_nx = T_PERIOD;
                    end else begin
                        timer_nx = timer_q - TW'(1);
                    end
                end
                S_COOLDOWN: begin
                    cnt_nx = '0;
                    if (expired) begin
                        state_nx = S_IDLE;
                    end else begin
                        timer_nx = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    timer_nx = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, timer, counter and output registers; outputs follow the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            soothe_q <= 1'b0;
            alarm_q  <= 1'b0;
            notify_q <= 1'b0;
        end else begin
            state_q  <= state_nx;
            timer_q  <= timer_nx;
            cnt_q    <= cnt_nx;
            soothe_q <= (state_nx == S_SOOTHE) || (state_nx == S_ALARM);
            alarm_q  <= (state_nx == S_ALARM);
            notify_q <= (state_nx == S_ALARM) && (timer_nx == '0);
        end
    end

    assign bus.state     = state_q;
    assign bus.cry_cnt   = cnt_q;
    assign bus.soothe_on = soothe_q;
    assign bus.alarm     = alarm_q;
    assign bus.notify    = notify_q;

endmodule

// File: doc/nursery_alert_ctrl.md
# nursery_alert_ctrl

Escalation controller that sits behind the baby-cry sequence detector in the smart-room nursery path. It counts the detector's one-cycle `cry` pulses inside a time window and escalates in stages: idle, then listening, then soothing (lullaby/night-light), then a parent alarm with periodic re-notification. After an acknowledge it holds a cooldown period, then returns to idle. Its outputs drive the soothing actuator and the parent notification interface.

## Interface
- `WINDOW`, 8: length of the listen window, in cycles (≥1).
- `CRY_THRESH`, 3: number of cries that escalates a stage (2..15).
- `SOOTHE_CYCLES`, 10: maximum soothing duration, in cycles (≥1).
- `ALARM_PERIOD`, 4: spacing of `notify` pulses while the alarm is active, in cycles (≥1).
- `COOLDOWN_CYCLES`, 5: cooldown duration, in cycles (≥1).
- `TW`, 16: width of the internal timer; every duration parameter must be ≤ 2^TW.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `enable` in 1: controller enable. When 0, the block is synchronously forced to IDLE.
- `cry` in 1: one-cycle pulse from the cry detector.
- `ack` in 1: parent acknowledge, level-sampled.
- `soothe_on` out 1: soothing actuator on.
- `alarm` out 1: parent alarm active.
- `notify` out 1: one-cycle re-notification pulse.
- `state` out 3: current state encoding, for debug.
- `cry_cnt` out 4: cries counted in the current stage.

## Operation
- States and encodings: IDLE=0, LISTEN=1, SOOTHE=2, ALARM=3, COOLDOWN=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- One shared timer (`TW` bits) and one cry counter (4 bits).
- The FSM is Moore. Outputs decode from registers only:
  - `soothe_on` = SOOTHE or ALARM.
  - `alarm` = ALARM.
  - `notify` = ALARM and timer==0.
- Global priority on every edge: `enable`=0 first, then `ack`, then the threshold, then timer expiry.
- `enable`=0 in any state: next state IDLE, timer=0, cry_cnt=0.
- IDLE:
  - `cry`=1 → LISTEN, timer=WINDOW−1, cry_cnt=1.
  - `ack` is ignored.
- LISTEN:
  - `cry` increments cry_cnt.
  - If the incremented value equals CRY_THRESH → SOOTHE, timer=SOOTHE_CYCLES−1, cry_cnt=0.
  - Otherwise, if timer==0 → IDLE, cry_cnt=0. Otherwise timer decrements.
  - A cry arriving on the timer==0 cycle is counted before the expiry check.
- SOOTHE:
  - `ack` → IDLE, counters cleared.
  - Otherwise cries count as in LISTEN; reaching CRY_THRESH → ALARM, timer=0, cry_cnt=0.
  - Otherwise timer==0 → COOLDOWN, timer=COOLDOWN_CYCLES−1. Otherwise timer decrements.
- ALARM:
  - `ack` → COOLDOWN, timer=COOLDOWN_CYCLES−1.
  - Otherwise timer==0 reloads ALARM_PERIOD−1; any other value decrements. There is no timeout: the alarm holds until `ack` or `enable`=0.
  - `cry` is ignored; cry_cnt holds 0.
- COOLDOWN:
  - `cry` and `ack` are ignored.
  - timer==0 → IDLE. Otherwise timer decrements.
- cry_cnt saturates at 15. It cannot exceed CRY_THRESH in normal operation.

## Timing
- Reset (`rstn`=0, asynchronous): state=IDLE, timer=0, cry_cnt=0, and all outputs 0 immediately, without waiting for a clock edge. Release is taken on the next rising edge.
- Latency: an input sampled at edge N is reflected in `state` and the outputs after edge N, i.e. one cycle.
- Dwell times with no further input:
  - LISTEN lasts exactly WINDOW cycles.
  - SOOTHE lasts SOOTHE_CYCLES cycles.
  - COOLDOWN lasts COOLDOWN_CYCLES cycles.
- `notify` is high in the first ALARM cycle, then every ALARM_PERIOD cycles. With ALARM_PERIOD=1 it stays high for the whole of ALARM.
- Simultaneous `cry` and `ack` in SOOTHE: `ack` wins and the state goes to IDLE.
- Reset asserted mid-ALARM drops `alarm`, `soothe_on` and `notify` asynchronously.

## Test plan
All scenarios use the default parameters. Cycles are counted from the first `cry` edge.
- **Reset mid-ALARM:** drive the block into ALARM, then pulse `rstn` low asynchronously between edges → all outputs 0 at once; state=0 after release.
- **Listen timeout:** `cry` at cycles 0 and 3 only → state=1 for 8 cycles, then state=0; `soothe_on` never asserts; cry_cnt reaches 2, then clears.
- **Escalate to SOOTHE:** `cry` at cycles 0, 2, 4 → state=2 and `soothe_on`=1 from cycle 5. With no more cries, COOLDOWN starts after 10 cycles, then IDLE after 5 more.
- **Escalate to ALARM and re-notify:** reach SOOTHE, then 3 cries → `alarm`=1. `notify` pulses in ALARM cycles 0, 4, 8. Then `ack` → state=4 on the next cycle and `alarm`=0.
- **Simultaneous events:**
  - In SOOTHE with cry_cnt=2, drive `cry`+`ack` together → state=0, not ALARM.
  - In LISTEN with cry_cnt=2, a `cry` on the timer==0 cycle → state=2.
- **Enable and ignore rules:**
  - `enable`=0 during ALARM → state=0 after one edge.
  - Cries during COOLDOWN → cry_cnt stays 0, and IDLE is still reached after 5 cycles.
